// File: rtl/fifo_wr_arbiter.sv
// Two-requester round-robin write arbiter in front of a shared FIFO.
// Optional drop counter enabled by defining FIFO_ARB_DROP_CNT_EN.
module fifo_wr_arbiter #(
    parameter int B = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic [B-1:0] data0,
    input  logic         req1,
    input  logic [B-1:0] data1,
    input  logic         full,
    output logic         wr,
    output logic [B-1:0] w_data,
    output logic [1:0]   pend,
    output logic         last_gnt,
    output logic [7:0]   drop_cnt
);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t       r_state;
    logic [B-1:0] r_hold0;
    logic [B-1:0] r_hold1;
    logic [B-1:0] r_wdata;
    logic [1:0]   r_pend;
    logic         r_last;
    logic         r_wr;

    logic [1:0]   w_req;
    logic [1:0]   w_cap;
    logic [1:0]   w_clr;
    logic         w_grant_ok;
    logic         w_gnt;

    assign w_req      = {req1, req0};
    assign w_cap      = w_req & ~r_pend;
    assign w_grant_ok = (r_state == IDLE) && !full && (r_pend != 2'b00);
    // On a tie, favour whoever was not granted last.
    assign w_gnt      = (r_pend == 2'b11) ? ~r_last : r_pend[1];
    assign w_clr      = w_grant_ok ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_hold0 <= '0;
            r_hold1 <= '0;
            r_wdata <= '0;
            r_pend  <= 2'b00;
            r_last  <= 1'b1;
            r_wr    <= 1'b0;
        end else begin
            r_wr   <= 1'b0;
            r_pend <= (r_pend | w_cap) & ~w_clr;
            if (w_cap[0]) r_hold0 <= data0;
            if (w_cap[1]) r_hold1 <= data1;
            case (r_state)
                IDLE: begin
                    if (w_grant_ok) begin
                        r_state <= WRITE;
                        r_wr    <= 1'b1;
                        r_wdata <= w_gnt ? r_hold1 : r_hold0;
                        r_last  <= w_gnt;
                    end
                end
                WRITE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wr       = r_wr;
    assign w_data   = r_wdata;
    assign pend     = r_pend;
    assign last_gnt = r_last;

`ifdef FIFO_ARB_DROP_CNT_EN
    logic [7:0] r_drop;
    logic [1:0] w_drop;
    logic [8:0] w_drop_sum;

    assign w_drop     = w_req & r_pend;
    assign w_drop_sum = {1'b0, r_drop} + 9'(w_drop[0]) + 9'(w_drop[1]);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_drop <= 8'd0;
        end else begin
            r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    assign drop_cnt = r_drop;
`else
    assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized + directed bench for fifo_wr_arbiter against a
// behavioural model of the arbitration rules.
module tb_fifo_wr_arbiter;

    localparam int B = 3;

    logic         clk = 1'b0;
    logic         reset, req0, req1, full;
    logic [B-1:0] data0, data1;
    logic         wr, last_gnt;
    logic [B-1:0] w_data;
    logic [1:0]   pend;
    logic [7:0]   drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    bit m_pend [2];
    int m_hold [2];
    int m_last, m_wd, m_drop;
    bit m_wr;

    fifo_wr_arbiter #(.B(B)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .data0(data0),
        .req1(req1), .data1(data1),
        .full(full), .wr(wr), .w_data(w_data),
        .pend(pend), .last_gnt(last_gnt),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit q0, input int d0,
                              input bit q1, input int d1, input bit f);
        bit q [2];
        int d [2];
        int g, nd;
        q[0] = q0; q[1] = q1; d[0] = d0; d[1] = d1;
        if (!r) begin
            m_pend[0] = 0; m_pend[1] = 0;
            m_hold[0] = 0; m_hold[1] = 0;
            m_last = 1; m_wd = 0; m_drop = 0; m_wr = 0;
            return;
        end
        g = -1;
        if (!m_wr && !f && (m_pend[0] || m_pend[1])) begin
            if (m_pend[0] && m_pend[1]) g = 1 - m_last;
            else g = m_pend[0] ? 0 : 1;
        end
        nd = 0;
        for (int i = 0; i < 2; i++) begin
            if (q[i]) begin
                if (m_pend[i]) nd++;
                else begin
                    m_pend[i] = 1;
                    m_hold[i] = d[i];
                end
            end
        end
        // a granted requester was pending, so its capture above was a drop
        if (g >= 0) begin
            m_pend[g] = 0;
            m_wd = m_hold[g];
            m_last = g;
        end
        m_wr = (g >= 0);
        m_drop = (m_drop + nd > 255) ? 255 : m_drop + nd;
    endtask

    task automatic cyc(input bit r, input bit q0, input int d0,
                       input bit q1, input int d1, input bit f);
        reset = r; req0 = q0; req1 = q1; full = f;
        data0 = B'(d0); data1 = B'(d1);
        @(posedge clk);
        model_edge(r, q0, d0, q1, d1, f);
        #1;
        chk("wr", int'(wr), int'(m_wr));
        chk("w_data", int'(w_data), m_wd);
        chk("pend", int'(pend), int'({m_pend[1], m_pend[0]}));
        chk("last_gnt", int'(last_gnt), m_last);
`ifdef FIFO_ARB_DROP_CNT_EN
        chk("drop_cnt", int'(drop_cnt), m_drop);
`else
        chk("drop_cnt", int'(drop_cnt), 0);
`endif
    endtask

    task automatic idle(input int n, input bit f);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, f);
    endtask

    initial begin
        reset = 0; req0 = 0; req1 = 0; full = 0; data0 = '0; data1 = '0;
        m_last = 1; m_wd = 0; m_drop = 0; m_wr = 0;

        // reset state
        cyc(0, 0, 0, 0, 0, 0);
        chk("rst_pend", int'(pend), 0);
        chk("rst_last", int'(last_gnt), 1);
        chk("rst_wr", int'(wr), 0);

        // single tick, latency
        cyc(1, 1, 5, 0, 0, 0);
        chk("t31_pend", int'(pend), 1);
        chk("t31_wr0", int'(wr), 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("t31_wr", int'(wr), 1);
        chk("t31_wd", int'(w_data), 5);
        chk("t31_pend2", int'(pend), 0);
        chk("t31_last", int'(last_gnt), 0);
        idle(2, 0);

        // simultaneous ticks after reset: 3 then 6
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 1, 3, 1, 6, 0);
        chk("t32_pend", int'(pend), 3);
        cyc(1, 0, 0, 0, 0, 0);
        chk("t32_wr_a", int'(wr), 1);
        chk("t32_wd_a", int'(w_data), 3);
        cyc(1, 0, 0, 0, 0, 0);
        chk("t32_gap", int'(wr), 0);
        chk("t32_hold", int'(w_data), 3);
        cyc(1, 0, 0, 0, 0, 0);
        chk("t32_wr_b", int'(wr), 1);
        chk("t32_wd_b", int'(w_data), 6);
        chk("t32_last", int'(last_gnt), 1);
        idle(2, 0);

        // held while full
        cyc(1, 0, 0, 1, 7, 1);
        idle(3, 1);
        chk("t33_wr", int'(wr), 0);
        chk("t33_pend", int'(pend), 2);
        cyc(1, 0, 0, 0, 0, 0);
        chk("t33_wr1", int'(wr), 1);
        chk("t33_wd", int'(w_data), 7);
        idle(2, 0);

        // drops while full
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 0, 0, 1);
        cyc(1, 1, 2, 0, 0, 1);
        cyc(1, 1, 4, 0, 0, 1);
`ifdef FIFO_ARB_DROP_CNT_EN
        chk("t34_drop", int'(drop_cnt), 2);
`else
        chk("t34_drop", int'(drop_cnt), 0);
`endif
        cyc(1, 0, 0, 0, 0, 0);
        chk("t34_wd", int'(w_data), 1);
        idle(2, 0);

        // reset during write
        cyc(1, 0, 0, 1, 2, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("t35_pre", int'(wr), 1);
        cyc(0, 1, 5, 1, 5, 0);
        chk("t35_wr", int'(wr), 0);
        chk("t35_pend", int'(pend), 0);
        chk("t35_last", int'(last_gnt), 1);
        chk("t35_drop", int'(drop_cnt), 0);
        cyc(1, 1, 4, 1, 6, 0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("t35_gnt", int'(last_gnt), 0);
        chk("t35_wd", int'(w_data), 4);
        idle(3, 0);

        // drop counter saturation
        for (int i = 0; i < 140; i++) cyc(1, 1, i, 1, i, 1);
`ifdef FIFO_ARB_DROP_CNT_EN
        chk("sat_drop", int'(drop_cnt), 255);
`else
        chk("sat_drop", int'(drop_cnt), 0);
`endif
        idle(4, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 63) != 0),
                ($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)),
                ($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)),
                ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter B, default 3: data word width in bits; matches the shared FIFO's B.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; reset=0 at a rising edge resets the block.
REQ-004 req0  input  1  requester 0 single-cycle request tick (e.g. debounced button tick).
REQ-005 data0  input  B  requester 0 write data, valid in the req0 cycle.
REQ-006 req1  input  1  requester 1 single-cycle request tick.
REQ-007 data1  input  B  requester 1 write data, valid in the req1 cycle.
REQ-008 full  input  1  full flag from the shared FIFO.
REQ-009 wr  output  1  registered one-cycle write strobe to the FIFO.
REQ-010 w_data  output  B  registered write data to the FIFO, valid while wr=1.
REQ-011 pend  output  2  per-requester pending flag; bit i set means hold register i holds an unwritten word.
REQ-012 last_gnt  output  1  index of the most recently granted requester.
REQ-013 drop_cnt  output  8  count of dropped requests; see Configuration.

Function
REQ-014 Capture: reqi=1 with pendi=0 at a rising edge shall load datai into hold register i and set pendi after that edge.
REQ-015 Drop: reqi=1 with pendi=1 at a rising edge shall be ignored; hold register i and pendi stay unchanged.
REQ-016 FSM states: IDLE and WRITE only.
REQ-017 IDLE, full=0, pend!=00: grant per REQ-018, go to WRITE; wr=1 and w_data=hold of the granted requester after the edge; pend bit of the granted requester cleared; last_gnt set to the granted index.
REQ-018 Grant choice: if only one pend bit is set, grant that requester; if both are set, grant the requester not equal to last_gnt (round-robin).
REQ-019 IDLE with full=1 or pend=00: stay in IDLE with wr=0; pending words are held indefinitely.
REQ-020 WRITE always returns to IDLE on the next edge with wr=0; at most one write every two cycles, so full is always current when sampled.
REQ-021 Latency: a tick at edge n into an idle, non-full, otherwise empty arbiter gives wr=1 in the cycle after edge n+1.
REQ-022 A reqi tick at the same edge that grants requester i is dropped (REQ-015); pendi reads 0 after that edge.
REQ-023 Both requesters ticking at the same edge are both captured; the arbiter writes them on consecutive grants, in the order given by REQ-018.
REQ-024 w_data holds its last value while wr=0.

Reset
REQ-025 A reset edge shall force: state=IDLE, wr=0, w_data=0, pend=00, last_gnt=1 (requester 0 wins the first tie), drop_cnt=0, hold registers=0.
REQ-026 Reset during WRITE shall abort the strobe; wr=0 after the reset edge.
REQ-027 Ticks coincident with a reset edge are discarded.

Configuration
REQ-028 Macro FIFO_ARB_DROP_CNT_EN defined: drop_cnt shall increment by 1 on every dropped tick (REQ-015/REQ-022), saturating at 255.
REQ-029 Two drops at the same edge shall add 2, saturating at 255.
REQ-030 Macro not defined: drop_cnt shall be tied to 0 and no counter logic shall be synthesized.

Verification
REQ-031 Reset, then req0 tick with data0=5, full=0 -> pend=01 next cycle; wr=1 with w_data=5 one cycle later; then pend=00 and last_gnt=0.
REQ-032 req0 (data 3) and req1 (data 6) tick at the same edge -> writes 3 then 6, each wr=1 for one cycle with one idle cycle between; last_gnt ends at 1.
REQ-033 full=1, then req1 tick with data1=7 -> wr stays 0 and pend=10 held; deassert full -> wr=1 with w_data=7 within 2 cycles.
REQ-034 With FIFO_ARB_DROP_CNT_EN, req0 ticks on 3 consecutive edges while full=1 -> first captured, drop_cnt=2, hold keeps the first data; without the macro, drop_cnt=0.
REQ-035 Assert reset while wr=1 -> wr=0, pend=00, last_gnt=1, drop_cnt=0 after the edge; a subsequent tie grants requester 0 first.
